// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor update scheduler.
//   bp_upd_entry_t : one resolved branch waiting to update the predictor
//   bp_upd_state_t : scheduler FSM state encoding
package bp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
    } bp_upd_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FORCE = 2'd2,
        DRAIN = 2'd3
    } bp_upd_state_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// Circular FIFO of resolved-branch entries.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (discards all entries)
//   push, push_data write one entry (caller guarantees !full)
//   pop             drop the head entry (caller guarantees !empty)
//   head            current head entry
//   count           number of stored entries, 0..DEPTH
//   full, empty     occupancy flags
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  bp_upd_entry_t            push_data,
    input  logic                     pop,
    output bp_upd_entry_t            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    bp_upd_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/bp_update_scheduler.sv
// Buffers committed branch outcomes and schedules them onto the predictor's
// single update port. Fetch lookups win the port unless the queue is too
// full, the head has waited too long, or a drain is requested.
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   commit_valid/pc/taken      resolved branch offered by commit
//   commit_ready               queue not full (registered count only)
//   fetch_pred_req             fetch owns the predictor this cycle
//   drain_req, drain_done      level drain request / queue emptied in drain
//   pc_to_update, branch_taken head entry, zero when not issuing
//   is_branch                  one predictor update this cycle
//   occupancy                  current queue count
// Optional (BP_UPD_STATS_EN defined): stat_issued, stat_forced, stat_full.
//
// state | meaning
// IDLE  | queue empty (or just left drain); fetch has priority
// ISSUE | entries queued; issue only in fetch-idle cycles
// FORCE | occupancy/age pressure; issue every cycle
// DRAIN | drain requested; issue every cycle until released
module bp_update_scheduler
    import bp_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int HI_WATER = 6,
    parameter int MAX_WAIT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     commit_valid,
    input  logic [31:0]              commit_pc,
    input  logic                     commit_taken,
    output logic                     commit_ready,
    input  logic                     fetch_pred_req,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic [31:0]              pc_to_update,
    output logic                     branch_taken,
    output logic                     is_branch,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef BP_UPD_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_forced,
    output logic [31:0]              stat_full
`endif
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int AGW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  HI_C    = CW'(HI_WATER);
    localparam logic [CW-1:0]  LO_C    = CW'(HI_WATER - 1);
    localparam logic [AGW-1:0] AGE_MAX = AGW'(MAX_WAIT);

    bp_upd_state_t  state, state_next;
    bp_upd_entry_t  head, push_data;
    logic [CW-1:0]  count, count_next;
    logic [AGW-1:0] age, age_next;
    logic           push, issue, full, empty, urgent;

    assign push_data = '{pc: commit_pc, taken: commit_taken};
    assign commit_ready = !full;
    assign push  = commit_valid && commit_ready;
    assign urgent = (state == FORCE) || (state == DRAIN);
    assign issue = !empty && (urgent || !fetch_pred_req);

    bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (issue),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        count_next = count;
        if (push && !issue)      count_next = count + 1'b1;
        else if (!push && issue) count_next = count - 1'b1;
    end

    // An entry pushed into an empty queue starts aging the following cycle.
    always_comb begin
        age_next = age;
        if (issue || empty)        age_next = '0;
        else if (age != AGE_MAX)   age_next = age + 1'b1;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (drain_req)             state_next = DRAIN;
                else if (count_next != '0) state_next = ISSUE;
            end
            ISSUE: begin
                if (drain_req)             state_next = DRAIN;
                else if (count_next == '0) state_next = IDLE;
                else if (count_next >= HI_C || age_next == AGE_MAX)
                                           state_next = FORCE;
            end
            FORCE: begin
                if (drain_req)             state_next = DRAIN;
                else if (count_next == '0) state_next = IDLE;
                else if (count_next < LO_C && age_next < AGE_MAX)
                                           state_next = ISSUE;
            end
            DRAIN: begin
                if (!drain_req)            state_next = IDLE;
            end
            default:                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            age   <= '0;
        end else begin
            state <= state_next;
            age   <= age_next;
        end
    end

    assign is_branch    = issue;
    assign pc_to_update = issue ? head.pc : 32'h0;
    assign branch_taken = issue && head.taken;
    assign occupancy    = count;
    assign drain_done   = drain_req && (state == DRAIN) && empty && !issue;

`ifdef BP_UPD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_issued <= '0;
            stat_forced <= '0;
            stat_full   <= '0;
        end else begin
            if (issue)                         stat_issued <= stat_issued + 1'b1;
            if (issue && urgent)               stat_forced <= stat_forced + 1'b1;
            if (commit_valid && !commit_ready) stat_full   <= stat_full + 1'b1;
        end
    end
`endif

endmodule
